apb_master_arb: RTL and testbench
=================================

Name: apb_master_arb

Overview:
Shares one APB master port between NUM_REQ independent requesters, using round-robin arbitration. It accepts one command at a time over a valid/ready interface, then sequences the APB SETUP and ACCESS phases. It waits for PREADY, with a timeout. It returns read data, or an error flag, to the winning requester. It sits between the testbench or CPU-side command sources and the DUT's APB slave, which is the FIFO register block.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_WIDTH, 8, APB address width
DATA_WIDTH, 32, APB data width
TIMEOUT, 16, maximum ACCESS cycles without PREADY before abort (>=2)

Ports:
PCLK  in  1  clock; all logic is on the rising edge
PRESET  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester command valid
req_ready  out  NUM_REQ  per-requester command accept (one-hot or zero)
req_write  in  NUM_REQ  per-requester direction: 1 = write
req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i is at slice [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester
rsp_rdata  out  DATA_WIDTH  read data; valid only while rsp_valid is nonzero
rsp_err  out  1  timeout error flag; qualified by rsp_valid
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_WIDTH  APB address
PWDATA  out  DATA_WIDTH  APB write data
PRDATA  in  DATA_WIDTH  APB read data
PREADY  in  1  APB ready

Behaviour:
- One clock (PCLK); reset is synchronous and active-high (PRESET). Every output is registered except req_ready.
- Reset values:
  - PSEL, PENABLE, PWRITE = 0; PADDR, PWDATA = 0
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0
  - FSM = IDLE, round-robin pointer = 0, timeout counter = 0
- FSM states are IDLE, SETUP and ACCESS.
- IDLE:
  - The round-robin winner is the first i with req_valid[i] set, searching upward from the pointer and wrapping.
  - req_ready is asserted combinationally for the winner only. A command is accepted when req_valid[i] and req_ready[i] are both high (cycle T).
  - On acceptance: latch write, addr, wdata and the owner index; go to SETUP.
  - The pointer is set to (owner+1) mod NUM_REQ at acceptance.
- SETUP (cycle T+1): PSEL=1, PENABLE=0; PADDR, PWDATA and PWRITE carry the latched values. Always advances to ACCESS.
- ACCESS (cycle T+2 onward): PSEL=1, PENABLE=1; PADDR, PWDATA and PWRITE are held stable.
  - PREADY=1 at a rising edge completes the transfer:
    - next cycle: PSEL=PENABLE=0 and rsp_valid[owner]=1 for exactly one cycle
    - rsp_rdata = PRDATA sampled on a read, or 0 on a write; rsp_err=0
    - FSM returns to IDLE
  - The timeout counter starts at 0 on entry to ACCESS and increments on each cycle with PREADY=0. If it reaches TIMEOUT-1 with PREADY=0, the transfer aborts: PSEL=PENABLE=0, rsp_valid[owner]=1, rsp_err=1, rsp_rdata=0, FSM to IDLE.
- Latency: with zero wait states, acceptance at T gives SETUP at T+1, ACCESS at T+2 and rsp_valid at T+3. The next acceptance is possible at T+3 (the IDLE cycle) with SETUP at T+4. Throughput is therefore 1 transfer per 3 cycles.
- req_ready is 0 in SETUP and ACCESS. Requesters hold req_* stable while req_valid is high. Deasserting req_valid before acceptance is allowed and is not an error.
- PADDR and PWDATA retain their last values in IDLE; only PSEL and PENABLE return to 0.
- If PREADY is asserted in SETUP, it is ignored.
- If a requester's rsp_valid and a new req_valid from the same requester occur in the same cycle, acceptance is legal in that cycle.
- PRESET mid-transfer: on the next edge all outputs take their reset values, no rsp_valid is issued, and the pending transfer is dropped.
- Timeout counter width is $clog2(TIMEOUT+1); it saturates and never wraps.

Decomposition:
- Package apb_arb_pkg holds:
  - state_t enum {IDLE, SETUP, ACCESS}
  - typedef apb_cmd_t {write, addr, wdata}, parameterised via ADDR_WIDTH/DATA_WIDTH localparams
- Sub-module rr_arbiter (NUM_REQ) handles round-robin selection:
  - inputs: req vector, pointer, enable
  - outputs: one-hot grant and binary index
  - purely combinational
- The top level owns the FSM, latch, timeout and response registers.

Test Plan:
- Single write: req0 write addr 0x04 data 0xDEADBEEF with PREADY tied 1 -> PSEL 1 at T+1, PENABLE 1 at T+2 with PADDR=0x04 and PWDATA=0xDEADBEEF, rsp_valid=4'b0001 at T+3, rsp_err=0.
- Read with 3 wait states: req2 reads 0x10, slave returns 0x12345678 after 3 PREADY=0 cycles -> PADDR stable through ACCESS, rsp_valid=4'b0100, rsp_rdata=0x12345678.
- Round-robin fairness: all 4 req_valid held high, 8 transfers -> grant order 0,1,2,3,0,1,2,3, with no requester granted twice in a row while others wait.
- Timeout: PREADY held 0 with TIMEOUT=16 -> ACCESS lasts exactly 16 cycles, then PSEL=0, rsp_valid for the owner, rsp_err=1, rsp_rdata=0; the next request is accepted normally.
- Reset mid-ACCESS: PRESET=1 for 1 cycle during the wait -> all outputs 0 on the next edge, no rsp_valid, pointer back to 0 (req1 and req3 pending -> req1 granted first).
- Back-to-back same requester: req1 valid continuously with zero-wait slave -> acceptances every 3 cycles, with PSEL low for exactly one cycle between transfers.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types for the APB master arbiter: FSM states, latched command record
// and the round-robin pointer helper.
package apb_arb_pkg;

  localparam int APB_ADDR_WIDTH = 8;
  localparam int APB_DATA_WIDTH = 32;

  // Transfer phases of the shared APB port.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Command captured from the winning requester at acceptance.
  typedef struct packed {
    logic                      write;
    logic [APB_ADDR_WIDTH-1:0] addr;
    logic [APB_DATA_WIDTH-1:0] wdata;
  } apb_cmd_t;

  // Index following idx in a ring of n requesters.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first asserted request at or above the
// pointer, wrapping past the top index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx
);

  logic             w_found;
  logic [IDX_W:0]   w_cand;
  logic [IDX_W-1:0] w_pos;

  // Scan the ring starting at the pointer and keep the first hit.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    w_pos   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, i_ptr} + (IDX_W+1)'(k);
      if (w_cand >= (IDX_W+1)'(NUM_REQ)) begin
        w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
      end
      w_pos = w_cand[IDX_W-1:0];
      if (i_en && !w_found && i_req[w_pos]) begin
        w_found        = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
      end
    end
  end

endmodule

// File: rtl/apb_master_arb.sv
// Shares one APB master port between NUM_REQ requesters. One command is in
// flight at a time; the owner gets a single-cycle rsp_valid pulse with read
// data, or with rsp_err set when the slave never raised PREADY.
//
// Command handshake: requester i's command transfers on a PCLK edge where
// req_valid[i] && req_ready[i]. Requesters hold req_* stable while valid is
// high and may drop valid before the transfer without penalty. req_ready is
// one-hot (the round-robin winner) in IDLE and zero otherwise.
module apb_master_arb
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH = APB_DATA_WIDTH,
  parameter int TIMEOUT    = 16
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [DATA_WIDTH-1:0]        rsp_rdata,
  output logic                         rsp_err,
  output logic                         PSEL,
  output logic                         PENABLE,
  output logic                         PWRITE,
  output logic [ADDR_WIDTH-1:0]        PADDR,
  output logic [DATA_WIDTH-1:0]        PWDATA,
  input  logic [DATA_WIDTH-1:0]        PRDATA,
  input  logic                         PREADY,
  output state_t                       dbg_state
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  // Registered state
  state_t                r_state;
  logic [IDX_W-1:0]      r_ptr;
  logic [IDX_W-1:0]      r_owner;
  apb_cmd_t              r_cmd;
  logic [TMO_W-1:0]      r_tmo;
  logic                  r_psel;
  logic                  r_penable;
  logic [NUM_REQ-1:0]    r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;

  // Next-state values
  state_t                w_state_nxt;
  logic [IDX_W-1:0]      w_ptr_nxt;
  logic [IDX_W-1:0]      w_owner_nxt;
  apb_cmd_t              w_cmd_nxt;
  logic [TMO_W-1:0]      w_tmo_nxt;
  logic                  w_psel_nxt;
  logic                  w_penable_nxt;
  logic [NUM_REQ-1:0]    w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] w_rsp_rdata_nxt;
  logic                  w_rsp_err_nxt;

  // Arbiter results
  logic [NUM_REQ-1:0]    w_grant;
  logic [IDX_W-1:0]      w_win_idx;
  logic                  w_accept;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .i_en    (r_state == IDLE),
    .o_grant (w_grant),
    .o_idx   (w_win_idx)
  );

  assign req_ready = w_grant;
  assign w_accept  = |w_grant;

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_cmd.write;
  assign PADDR     = r_cmd.addr;
  assign PWDATA    = r_cmd.wdata;
  assign dbg_state = r_state;

  // Next state and next values of every registered output.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_owner_nxt     = r_owner;
    w_cmd_nxt       = r_cmd;
    w_tmo_nxt       = r_tmo;
    w_psel_nxt      = r_psel;
    w_penable_nxt   = r_penable;
    w_rsp_valid_nxt = '0;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt     = SETUP;
          w_owner_nxt     = w_win_idx;
          w_cmd_nxt.write = req_write[w_win_idx];
          w_cmd_nxt.addr  = req_addr[w_win_idx*ADDR_WIDTH +: ADDR_WIDTH];
          w_cmd_nxt.wdata = req_wdata[w_win_idx*DATA_WIDTH +: DATA_WIDTH];
          w_ptr_nxt       = IDX_W'(rr_next(32'(w_win_idx), NUM_REQ));
          w_psel_nxt      = 1'b1;
          w_penable_nxt   = 1'b0;
        end
      end
      SETUP: begin
        // PREADY is not looked at here; the slave only answers in ACCESS.
        w_state_nxt   = ACCESS;
        w_penable_nxt = 1'b1;
        w_tmo_nxt     = '0;
      end
      ACCESS: begin
        if (PREADY) begin
          w_state_nxt              = IDLE;
          w_psel_nxt               = 1'b0;
          w_penable_nxt            = 1'b0;
          w_rsp_valid_nxt[r_owner] = 1'b1;
          w_rsp_rdata_nxt          = r_cmd.write ? '0 : PRDATA;
          w_rsp_err_nxt            = 1'b0;
        end else if (r_tmo >= TMO_LAST) begin
          // Slave never answered: release the bus and report the error.
          w_state_nxt              = IDLE;
          w_psel_nxt               = 1'b0;
          w_penable_nxt            = 1'b0;
          w_rsp_valid_nxt[r_owner] = 1'b1;
          w_rsp_rdata_nxt          = '0;
          w_rsp_err_nxt            = 1'b1;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pointer, latched command, timeout counter and registered outputs.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_ptr       <= '0;
      r_owner     <= '0;
      r_cmd       <= '0;
      r_tmo       <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_ptr       <= w_ptr_nxt;
      r_owner     <= w_owner_nxt;
      r_cmd       <= w_cmd_nxt;
      r_tmo       <= w_tmo_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

endmodule

// File: tb/tb_apb_master_arb.sv
// Bench for apb_master_arb: transaction-level reference model, per-cycle
// compare process, directed scenarios and a randomized soak.
module tb_apb_master_arb;
  import apb_arb_pkg::*;

  localparam int N   = 4;
  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int TMO = 16;

  // ---------------- clock / reset / DUT ----------------
  logic              PCLK = 1'b0;
  logic              PRESET;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      req_write;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [N-1:0]      rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [AW-1:0]     PADDR;
  logic [DW-1:0]     PWDATA;
  logic [DW-1:0]     PRDATA;
  logic              PREADY;
  state_t            dbg_state;

  always #5 PCLK = ~PCLK;

  apb_master_arb #(
    .NUM_REQ    (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TMO)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .dbg_state (dbg_state)
  );

  // ---------------- check bookkeeping ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // A transfer is described by its age since acceptance (1 = address phase)
  // and the number of enable-phase cycles spent so far.
  bit            m_init = 1'b0;
  bit            m_busy;
  int            m_age, m_acc, m_owner, m_ptr, m_w;
  logic          m_write;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          e_psel, e_penable, e_pwrite, e_rsp_err;
  logic [AW-1:0] e_paddr;
  logic [DW-1:0] e_pwdata, e_rsp_rdata;
  logic [N-1:0]  e_rsp_valid;

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  always @(posedge PCLK) begin : model_proc
    if (PRESET) begin
      m_init = 1'b1; m_busy = 1'b0; m_age = 0; m_acc = 0; m_owner = 0; m_ptr = 0;
      m_write = 1'b0; m_addr = '0; m_wdata = '0;
      e_psel = 1'b0; e_penable = 1'b0; e_pwrite = 1'b0; e_paddr = '0; e_pwdata = '0;
      e_rsp_valid = '0; e_rsp_rdata = '0; e_rsp_err = 1'b0;
    end else if (m_init) begin
      e_rsp_valid = '0;
      if (!m_busy) begin
        m_w = pick(req_valid, m_ptr);
        if (m_w >= 0) begin
          m_busy = 1'b1; m_age = 1; m_owner = m_w;
          m_write = req_write[m_w];
          m_addr  = req_addr[m_w*AW +: AW];
          m_wdata = req_wdata[m_w*DW +: DW];
          m_ptr   = (m_w + 1) % N;
          e_psel = 1'b1; e_penable = 1'b0;
          e_pwrite = m_write; e_paddr = m_addr; e_pwdata = m_wdata;
        end
      end else if (m_age == 1) begin
        m_age = 2; m_acc = 0; e_penable = 1'b1;
      end else begin
        m_acc = m_acc + 1;
        if (PREADY === 1'b1) begin
          e_psel = 1'b0; e_penable = 1'b0; e_rsp_valid[m_owner] = 1'b1;
          e_rsp_rdata = m_write ? '0 : PRDATA; e_rsp_err = 1'b0; m_busy = 1'b0;
        end else if (m_acc == TMO) begin
          e_psel = 1'b0; e_penable = 1'b0; e_rsp_valid[m_owner] = 1'b1;
          e_rsp_rdata = '0; e_rsp_err = 1'b1; m_busy = 1'b0;
        end
      end
    end
  end

  // ---------------- compare process + grant monitor ----------------
  int grant_q[$];
  int grant_cyc_q[$];
  int cyc = 0;

  always @(negedge PCLK) begin : compare_proc
    logic [N-1:0] e_ready;
    int           w;
    state_t       e_state;
    cyc++;
    if (m_init) begin
      e_ready = '0;
      if (!m_busy) begin
        w = pick(req_valid, m_ptr);
        if (w >= 0) e_ready[w] = 1'b1;
      end
      e_state = !m_busy ? IDLE : ((m_age == 1) ? SETUP : ACCESS);
      chk("req_ready", req_ready, e_ready);
      chk("psel", PSEL, e_psel);
      chk("penable", PENABLE, e_penable);
      chk("pwrite", PWRITE, e_pwrite);
      chk("paddr", PADDR, e_paddr);
      chk("pwdata", PWDATA, e_pwdata);
      chk("rsp_valid", rsp_valid, e_rsp_valid);
      chk("state", dbg_state, e_state);
      if (e_rsp_valid != 0 || rsp_valid != 0) begin
        chk("rsp_rdata", rsp_rdata, e_rsp_rdata);
        chk("rsp_err", rsp_err, e_rsp_err);
      end
      if (!PRESET) begin
        for (int k = 0; k < N; k++) begin
          if (req_valid[k] && req_ready[k]) begin
            grant_q.push_back(k);
            grant_cyc_q.push_back(cyc);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  bit            hold    = 1'b0;
  bit            rand_en = 1'b0;
  int            slave_mode = 0;   // 0 ready, 1 mostly ready, 2 fixed waits, 3 never, 4 rarely
  int            wait_n = 0;
  int            acc_cnt = 0;
  logic [DW-1:0] slave_data = '0;

  task automatic set_req(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = 1'b1;
    req_write[i]          = wr;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  // Advance one cycle; return at posedge+1 with fresh outputs and new inputs.
  task automatic tick();
    logic [N-1:0] acc;
    @(negedge PCLK);
    acc = req_valid & req_ready & {N{!PRESET}};
    @(posedge PCLK);
    #1;
    if (!hold) req_valid = req_valid & ~acc;
    if (PSEL && PENABLE) acc_cnt++; else acc_cnt = 0;
    case (slave_mode)
      0: PREADY = 1'b1;
      1: PREADY = ($urandom_range(0, 3) != 0);
      2: PREADY = (acc_cnt > wait_n);
      3: PREADY = 1'b0;
      default: PREADY = ($urandom_range(0, 19) == 0);
    endcase
    PRDATA = (slave_mode == 2) ? slave_data : $urandom;
    if (rand_en) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i]) begin
          if ($urandom_range(0, 29) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          set_req(i, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
        end
      end
    end
  endtask

  task automatic do_reset();
    PRESET    = 1'b1;
    req_valid = '0;
    hold      = 1'b0;
    tick();
    tick();
    PRESET = 1'b0;
    grant_q.delete();
    grant_cyc_q.delete();
  endtask

  task automatic wait_rsp(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (rsp_valid != 0) begin
        seen = 1'b1;
        return;
      end
    end
  endtask

  // ---------------- scoreboard queue / scenarios ----------------
  logic [1:0] exp_q[$];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, n_pass=%0d n_total=%0d", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit seen;
    int cnt;
    PRESET = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    PRDATA = '0; PREADY = 1'b0;
    do_reset();

    // Reset values
    chk("rst_psel", PSEL, 1'b0);
    chk("rst_paddr", PADDR, 8'h00);
    chk("rst_rsp_valid", rsp_valid, 4'b0000);

    // Single write, zero wait states
    slave_mode = 0;
    set_req(0, 1'b1, 8'h04, 32'hDEADBEEF);
    #1 chk("t1_ready", req_ready, 4'b0001);
    tick();
    chk("t1_setup_psel", PSEL, 1'b1);
    chk("t1_setup_penable", PENABLE, 1'b0);
    chk("t1_setup_paddr", PADDR, 8'h04);
    tick();
    chk("t1_access_penable", PENABLE, 1'b1);
    chk("t1_access_paddr", PADDR, 8'h04);
    chk("t1_access_pwdata", PWDATA, 32'hDEADBEEF);
    chk("t1_access_pwrite", PWRITE, 1'b1);
    tick();
    chk("t1_rsp_valid", rsp_valid, 4'b0001);
    chk("t1_rsp_err", rsp_err, 1'b0);
    chk("t1_rsp_rdata", rsp_rdata, 32'h0);
    chk("t1_psel_low", PSEL, 1'b0);

    // Read with three wait states
    slave_mode = 2; wait_n = 3; slave_data = 32'h12345678;
    set_req(2, 1'b0, 8'h10, 32'h0);
    tick();
    chk("t2_setup_psel", PSEL, 1'b1);
    for (int k = 2; k <= 5; k++) begin
      tick();
      chk("t2_access_penable", PENABLE, 1'b1);
      chk("t2_access_paddr", PADDR, 8'h10);
      chk("t2_no_rsp", rsp_valid, 4'b0000);
    end
    tick();
    chk("t2_rsp_valid", rsp_valid, 4'b0100);
    chk("t2_rsp_rdata", rsp_rdata, 32'h12345678);
    chk("t2_rsp_err", rsp_err, 1'b0);

    // Round-robin fairness with all requesters pending
    do_reset();
    slave_mode = 0; hold = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
    for (int k = 0; k < 8; k++) exp_q.push_back(2'(k % 4));
    for (int c = 0; c < 60 && grant_q.size() < 8; c++) tick();
    hold = 1'b0; req_valid = '0;
    chk("t3_grant_count", 64'(grant_q.size()), 64'd8);
    for (int k = 0; k < 8 && k < grant_q.size(); k++) chk("t3_grant_order", 64'(grant_q[k]), 64'(exp_q[k]));
    exp_q.delete();
    for (int c = 0; c < 4; c++) tick();

    // Timeout: slave never ready
    slave_mode = 3;
    set_req(3, 1'b0, 8'h20, 32'h0);
    cnt = 0; seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      tick();
      if (PENABLE) cnt++;
      if (rsp_valid != 0) begin
        seen = 1'b1;
        chk("t4_rsp_valid", rsp_valid, 4'b1000);
        chk("t4_rsp_err", rsp_err, 1'b1);
        chk("t4_rsp_rdata", rsp_rdata, 32'h0);
        chk("t4_psel_low", PSEL, 1'b0);
      end
    end
    chk("t4_rsp_seen", seen, 1'b1);
    chk("t4_access_len", 64'(cnt), 64'd16);
    slave_mode = 0;
    set_req(0, 1'b1, 8'h30, 32'hA5A5A5A5);
    wait_rsp(seen);
    chk("t4_next_seen", seen, 1'b1);
    chk("t4_next_rsp_valid", rsp_valid, 4'b0001);
    chk("t4_next_rsp_err", rsp_err, 1'b0);

    // Reset in the middle of an ACCESS wait
    do_reset();
    slave_mode = 3;
    set_req(2, 1'b0, 8'h44, 32'h0);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (PENABLE) seen = 1'b1;
    end
    chk("t5_reached_access", seen, 1'b1);
    tick(); tick(); tick();
    hold = 1'b1;
    set_req(1, 1'b1, 8'h51, 32'h1111);
    set_req(3, 1'b1, 8'h53, 32'h3333);
    PRESET = 1'b1;
    tick();
    chk("t5_psel", PSEL, 1'b0);
    chk("t5_penable", PENABLE, 1'b0);
    chk("t5_pwrite", PWRITE, 1'b0);
    chk("t5_paddr", PADDR, 8'h00);
    chk("t5_pwdata", PWDATA, 32'h0);
    chk("t5_rsp_valid", rsp_valid, 4'b0000);
    chk("t5_rsp_err", rsp_err, 1'b0);
    PRESET = 1'b0;
    grant_q.delete(); grant_cyc_q.delete();
    #1 chk("t5_ready_after_reset", req_ready, 4'b0010);
    slave_mode = 0;
    for (int c = 0; c < 10 && grant_q.size() == 0; c++) tick();
    hold = 1'b0; req_valid = '0;
    chk("t5_first_grant", 64'(grant_q.size() > 0 ? grant_q[0] : -1), 64'd1);
    for (int c = 0; c < 6; c++) tick();

    // Back-to-back commands from one requester
    do_reset();
    slave_mode = 0; hold = 1'b1;
    set_req(1, 1'b1, 8'h08, 32'h00000011);
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("t6_psel_pattern", PSEL, 1'((k % 3) != 0));
    end
    hold = 1'b0; req_valid = '0;
    chk("t6_grant_count", 64'(grant_cyc_q.size()), 64'd3);
    for (int k = 1; k < grant_cyc_q.size(); k++)
      chk("t6_grant_spacing", 64'(grant_cyc_q[k] - grant_cyc_q[k-1]), 64'd3);
    for (int c = 0; c < 4; c++) tick();

    // Randomized soak
    do_reset();
    rand_en = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) begin
        case ($urandom_range(0, 2))
          0: slave_mode = 0;
          1: slave_mode = 1;
          default: slave_mode = 4;
        endcase
      end
      PRESET = ($urandom_range(0, 399) == 0);
      tick();
    end
    PRESET = 1'b0;
    rand_en = 1'b0; req_valid = '0; slave_mode = 0;
    for (int c = 0; c < 40; c++) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
